fb_frame_scheduler: RTL

- Owns the framebuffer GPU-side write port (wea/addra/dina) and sequences each frame as CLEAR, then DRAW, then WAIT_SWAP.
- After each buffer swap (vsync falling edge) it sweeps the new back buffer with a clear colour. It then grants the rasterizer a valid/ready pixel-write channel until the rasterizer signals frame end.
- Sits between the rasterizer and framebuffer. It uses the same vsync edge rule as the framebuffer swap, so both stay in lock-step.

---
 rtl/fb_pkg.sv | 16 +
 rtl/fb_frame_scheduler_if.sv | 26 ++
 rtl/fb_vsync_edge.sv | 21 ++
 rtl/fb_frame_scheduler.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Framebuffer scheduler package: frame-phase states and framebuffer geometry.
package fb_pkg;

  // Frame phases: sweep with clear colour, rasterizer draws, idle until buffer swap.
  typedef enum logic [1:0] {
    FS_CLEAR     = 2'd0,
    FS_DRAW      = 2'd1,
    FS_WAIT_SWAP = 2'd2
  } fb_state_t;

  localparam int FB_WIDTH      = 320;
  localparam int FB_HEIGHT     = 240;
  localparam int FB_PIXELS     = FB_WIDTH * FB_HEIGHT;
  localparam int FB_ADDR_WIDTH = 17;

endpackage

// File: rtl/fb_frame_scheduler_if.sv
// Rasterizer pixel channel plus framebuffer write port, as seen by the scheduler.
// master: rasterizer / framebuffer side. slave: the scheduler.
interface fb_frame_scheduler_if
  import fb_pkg::*;
#(
  parameter int ADDR_WIDTH = FB_ADDR_WIDTH
);
  logic                  pix_valid;
  logic                  pix_ready;
  logic [ADDR_WIDTH-1:0] pix_addr;
  logic [7:0]            pix_color;
  logic                  frame_end;
  logic                  fb_wea;
  logic [ADDR_WIDTH-1:0] fb_addra;
  logic [7:0]            fb_dina;

  modport master (
    output pix_valid, pix_addr, pix_color, frame_end,
    input  pix_ready, fb_wea, fb_addra, fb_dina
  );

  modport slave (
    input  pix_valid, pix_addr, pix_color, frame_end,
    output pix_ready, fb_wea, fb_addra, fb_dina
  );
endinterface

// File: rtl/fb_vsync_edge.sv
// Buffer-swap detector: registers vsync and flags its falling edge.
// The framebuffer uses this same block so both toggle on the identical condition.
module fb_vsync_edge (
  input  logic clk,
  input  logic reset,
  input  logic vsync,
  output logic vsync_fall
);
  logic prev_vsync_r;

  // Previous-cycle copy of vsync.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_vsync_r <= 1'b0;
    end else begin
      prev_vsync_r <= vsync;
    end
  end

  assign vsync_fall = prev_vsync_r & ~vsync;
endmodule

// File: rtl/fb_frame_scheduler.sv
// Frame scheduler: owns the framebuffer write port and runs CLEAR -> DRAW -> WAIT_SWAP.
// A vsync falling edge (buffer swap) from any state restarts the clear sweep; if the
// frame was not finished yet, frame_overrun pulses.
// Optional macro FB_OVERRUN_COUNT_EN adds a saturating 16-bit overrun_count output.
module fb_frame_scheduler
  import fb_pkg::*;
#(
  parameter int ADDR_WIDTH = FB_ADDR_WIDTH,
  parameter int NUM_PIXELS = FB_PIXELS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                vsync,
  input  logic [7:0]          clear_color,
  fb_frame_scheduler_if.slave bus,
  output logic                busy_clear,
  output logic                frame_overrun
`ifdef FB_OVERRUN_COUNT_EN
  ,
  output logic [15:0]         overrun_count
`endif
);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_PIXELS - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  fb_state_t             state_r, state_nxt_s;
  logic [ADDR_WIDTH-1:0] cnt_r, cnt_nxt_s, clr_cnt_s;
  logic [7:0]            colour_r, colour_nxt_s, clr_col_s;
  logic                  pending_r, pending_nxt_s;
  logic                  fb_wea_r, wea_nxt_s;
  logic [ADDR_WIDTH-1:0] fb_addra_r, addr_nxt_s;
  logic [7:0]            fb_dina_r, dina_nxt_s;
  logic                  overrun_r, overrun_nxt_s;
  logic                  vsync_fall_s;

  fb_vsync_edge u_vsync_edge (
    .clk        (clk),
    .reset      (reset),
    .vsync      (vsync),
    .vsync_fall (vsync_fall_s)
  );

  // Next-state, clear sweep and write-port decision for the coming cycle.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    colour_nxt_s  = colour_r;
    pending_nxt_s = pending_r;
    wea_nxt_s     = 1'b0;
    addr_nxt_s    = fb_addra_r;
    dina_nxt_s    = fb_dina_r;
    overrun_nxt_s = 1'b0;
    // A swap restarts the sweep at address 0 with the colour present at the edge.
    // pending_r stands in for "colour latched at reset": the first sweep after
    // reset takes clear_color live on its first write.
    clr_cnt_s = vsync_fall_s ? ADDR_ZERO : cnt_r;
    clr_col_s = (vsync_fall_s || pending_r) ? clear_color : colour_r;
    if (vsync_fall_s || (state_r == FS_CLEAR)) begin
      // Clear write; on a swap this also replaces any pixel handshaked this cycle.
      wea_nxt_s     = 1'b1;
      addr_nxt_s    = clr_cnt_s;
      dina_nxt_s    = clr_col_s;
      colour_nxt_s  = clr_col_s;
      pending_nxt_s = 1'b0;
      overrun_nxt_s = vsync_fall_s && (state_r != FS_WAIT_SWAP);
      if (clr_cnt_s == LAST_ADDR) begin
        state_nxt_s = FS_DRAW;
        cnt_nxt_s   = ADDR_ZERO;
      end else begin
        state_nxt_s = FS_CLEAR;
        cnt_nxt_s   = clr_cnt_s + ADDR_ONE;
      end
    end else begin
      case (state_r)
        FS_DRAW: begin
          if (bus.pix_valid) begin
            wea_nxt_s  = 1'b1;
            addr_nxt_s = bus.pix_addr;
            dina_nxt_s = bus.pix_color;
          end else begin
            wea_nxt_s  = 1'b0;
          end
          if (bus.frame_end) begin
            state_nxt_s = FS_WAIT_SWAP;
          end else begin
            state_nxt_s = FS_DRAW;
          end
        end
        FS_WAIT_SWAP: begin
          state_nxt_s = FS_WAIT_SWAP;
        end
        default: begin
          // Unused encoding: recover by restarting the sweep.
          state_nxt_s = FS_CLEAR;
          cnt_nxt_s   = ADDR_ZERO;
        end
      endcase
    end
  end

  // State, sweep counter, latched colour and registered write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= FS_CLEAR;
      cnt_r      <= ADDR_ZERO;
      colour_r   <= 8'h00;
      pending_r  <= 1'b1;
      fb_wea_r   <= 1'b0;
      fb_addra_r <= ADDR_ZERO;
      fb_dina_r  <= 8'h00;
      overrun_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      colour_r   <= colour_nxt_s;
      pending_r  <= pending_nxt_s;
      fb_wea_r   <= wea_nxt_s;
      fb_addra_r <= addr_nxt_s;
      fb_dina_r  <= dina_nxt_s;
      overrun_r  <= overrun_nxt_s;
    end
  end

`ifdef FB_OVERRUN_COUNT_EN
  logic [15:0] overrun_count_r;

  // Saturating count of overrun pulses, updated together with the pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun_count_r <= 16'h0000;
    end else if (overrun_nxt_s && (overrun_count_r != 16'hFFFF)) begin
      overrun_count_r <= overrun_count_r + 16'h0001;
    end else begin
      overrun_count_r <= overrun_count_r;
    end
  end

  assign overrun_count = overrun_count_r;
`endif

  assign bus.pix_ready  = (state_r == FS_DRAW);
  assign bus.fb_wea     = fb_wea_r;
  assign bus.fb_addra   = fb_addra_r;
  assign bus.fb_dina    = fb_dina_r;
  assign busy_clear     = (state_r == FS_CLEAR);
  assign frame_overrun  = overrun_r;
endmodule
